// File: rtl/bounce_gen.sv
// Contact-bounce emulator: turns a clean level request into a pseudo-random bouncing waveform.
// Define BOUNCE_GEN_STATS_EN to build the completed-event counter on event_count.
module bounce_gen #(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned MAX_BOUNCES   = 8,
  parameter int unsigned MIN_GAP       = 16,
  parameter logic [7:0]  GAP_MASK      = 8'h3F,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        level_in,
  output logic        btn_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] event_count
);

  localparam logic [15:0]      SeedEff  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]      LfsrMask = 16'hB400;
  localparam logic [7:0]       BncMask  = 8'(MAX_BOUNCES - 1);
  localparam logic [CNT_W-1:0] MinGapM1 = CNT_W'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] SettleM1 = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBounce, StSettle} state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             btn_q, btn_d;
  logic             tgt_q, tgt_d;
  logic [8:0]       tog_q, tog_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] set_q, set_d;
  logic [CNT_W-1:0] phase_m1;
  logic [8:0]       tog_init;

  assign lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
  // Counter reload is phase length minus one, drawn from the current LFSR value.
  assign phase_m1 = MinGapM1 + CNT_W'(lfsr_q[7:0] & GAP_MASK);
  // Remaining toggles after the first edge: 2n-2 with n = 1 + masked bits.
  assign tog_init = {lfsr_q[15:8] & BncMask, 1'b0};

  always_comb begin
    state_d = state_q;
    btn_d   = btn_q;
    tgt_d   = tgt_q;
    tog_d   = tog_q;
    gap_d   = gap_q;
    set_d   = set_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_in != tgt_q) begin
          tgt_d   = level_in;
          btn_d   = ~btn_q;
          tog_d   = tog_init;
          gap_d   = phase_m1;
          state_d = StBounce;
        end
      end
      StBounce: begin
        if (gap_q == '0) begin
          if (tog_q != '0) begin
            btn_d = ~btn_q;
            tog_d = tog_q - 9'd1;
            gap_d = phase_m1;
          end else begin
            set_d   = SettleM1;
            state_d = StSettle;
          end
        end else begin
          gap_d = gap_q - CNT_W'(1);
        end
      end
      StSettle: begin
        if (set_q == '0) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          set_d = set_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= SeedEff;
      btn_q   <= 1'b0;
      tgt_q   <= 1'b0;
      tog_q   <= '0;
      gap_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      btn_q   <= btn_d;
      tgt_q   <= tgt_d;
      tog_q   <= tog_d;
      gap_q   <= gap_d;
      set_q   <= set_d;
    end
  end

  assign btn_out = btn_q;
  assign busy    = (state_q != StIdle);

`ifdef BOUNCE_GEN_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else if (done) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign event_count = cnt_q;
`else
  assign event_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: event-schedule model of the default build plus directed literal checks.
module tb_bounce_gen;

  localparam int LfN     = 65536;
  localparam int MinGap  = 16;
  localparam int GapMask = 63;
  localparam int MaxB    = 8;
  localparam int Settle  = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        level = 1'b0;
  logic        level_s = 1'b0;
  logic        btn, busy, done;
  logic [15:0] evc;
  logic        btn_s, busy_s, done_s;
  logic [15:0] evc_s;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bounce_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .level_in   (level),
    .btn_out    (btn),
    .busy       (busy),
    .done       (done),
    .event_count(evc)
  );

  bounce_gen #(
    .MAX_BOUNCES  (1),
    .MIN_GAP      (4),
    .GAP_MASK     (8'h00),
    .SETTLE_CYCLES(8)
  ) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .level_in   (level_s),
    .btn_out    (btn_s),
    .busy       (busy_s),
    .done       (done_s),
    .event_count(evc_s)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int plen(input logic [15:0] v);
    return MinGap + int'(v[7:0] & 8'(GapMask));
  endfunction

  // Model state: p counts clock edges since reset release; tq holds scheduled toggle edges.
  logic [15:0] lf [LfN];
  int          p = 0;
  bit          act = 1'b0;
  logic        tgt_m = 1'b0;
  logic        btn_m = 1'b0;
  int          endp = 0;
  int          tq[$];
  logic [15:0] cnt_m = 16'h0000;

  initial begin
    int e;
    int n;
    lf[0] = 16'hACE1;
    for (int i = 1; i < LfN; i++) lf[i] = (lf[i-1] >> 1) ^ (lf[i-1][0] ? 16'hB400 : 16'h0000);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        p = 0; act = 1'b0; tgt_m = 1'b0; btn_m = 1'b0; endp = 0;
        tq.delete();
      end else begin
        p++;
        if (!act && level != tgt_m) begin
          tgt_m = level;
          act   = 1'b1;
          e     = p;
          n     = 1 + int'(lf[e-1][15:8] & 8'(MaxB - 1));
          for (int k = 0; k < 2 * n - 1; k++) begin
            tq.push_back(e);
            e += plen(lf[e-1]);
          end
          endp = e + Settle;
        end else if (act && p == endp) begin
          act = 1'b0;
`ifdef BOUNCE_GEN_STATS_EN
          cnt_m = cnt_m + 16'd1;
`endif
        end
        while (tq.size() > 0 && tq[0] == p) begin
          btn_m = ~btn_m;
          void'(tq.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("btn", btn, btn_m);
      chk("busy", busy, act);
      chk("done", done, act && (p == endp - 1));
      chk("event_count", evc, cnt_m);
    end
  end

  // Direct waveform measurements on the default DUT.
  int   edges = 0;
  int   last_edges = 0;
  int   cyc = 0;
  int   last_edge_cyc = 0;
  logic prev_btn = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        edges = 0;
        prev_btn = 1'b0;
      end else begin
        if (btn != prev_btn) begin
          if (edges > 0) begin
            chk("phase_ge_16", (cyc - last_edge_cyc) >= 16, 1);
            chk("phase_le_79", (cyc - last_edge_cyc) <= 79, 1);
          end
          edges++;
          last_edge_cyc = cyc;
          prev_btn = btn;
        end
        if (done) begin
          chk("edges_odd", edges % 2, 1);
          chk("edges_le_15", edges <= 15, 1);
          last_edges = edges;
          edges = 0;
        end
      end
    end
  end

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 6000);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int bsy;
    int dn;
    int stay;
    int k;
    repeat (3) @(negedge clk);
    chk("rst_btn", btn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_evc", evc, 0);
    chk("model_lf1", lf[1], 16'hE270);
    chk("model_lf2", lf[2], 16'h7138);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single clean edge: 4-cycle phase then 8-cycle settle.
    level_s = 1'b1;
    chk("s_latency", btn_s, 0);
    @(negedge clk);
    chk("s_first_edge", btn_s, 1);
    chk("s_busy_start", busy_s, 1);
    bsy = 1; dn = 0; stay = 1;
    repeat (19) begin
      @(negedge clk);
      if (busy_s) bsy++;
      if (done_s) dn++;
      if (!btn_s) stay = 0;
    end
    chk("s_busy_cycles", bsy, 12);
    chk("s_done_pulses", dn, 1);
    chk("s_btn_stays_high", stay, 1);

    // Default event 0->1.
    level = 1'b1;
    wait_done();
    repeat (3) @(negedge clk);
    chk("ev1_btn", btn, 1);
    chk("ev1_busy", busy, 0);

    // Request wiggles during BOUNCE are ignored.
    level = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    level = 1'b1;
    repeat (10) @(negedge clk);
    level = 1'b0;
    repeat (5) @(negedge clk);
    level = 1'b1;
    wait_done();
    repeat (5) @(negedge clk);
    chk("ignore_btn", btn, 1);
    chk("ignore_busy", busy, 0);
`ifdef BOUNCE_GEN_STATS_EN
    chk("stats_3", evc, 3);
`else
    chk("stats_off", evc, 0);
`endif

    // Request returns to old level during SETTLE: new event right after done.
    level = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    level = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((endp - p) >= 500 && k < 6000);
    if (k >= 6000) chk("settle_timeout", 0, 1);
    level = 1'b0;
    wait_done();
    @(negedge clk);
    chk("retrig_idle_gap", busy, 0);
    @(negedge clk);
    chk("retrig_busy", busy, 1);
    chk("retrig_first_edge", btn, 0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("retrig_final_btn", btn, 0);
    chk("retrig_final_busy", busy, 0);

    // Asynchronous reset mid-BOUNCE, then a fresh event from the seed.
    level = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_btn", btn, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_btn", btn, 0);
    chk("async_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("fresh_edge1", btn, 1);
    repeat (48) @(negedge clk);
    chk("fresh_hold49", btn, 1);
    @(negedge clk);
    chk("fresh_edge2", btn, 0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("fresh_edge_count", last_edges, 9);
    chk("fresh_final_btn", btn, 1);
`ifdef BOUNCE_GEN_STATS_EN
    chk("stats_after_rst", evc, 1);
`else
    chk("stats_off_end", evc, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
